// File: rtl/fp_minmax_reduce.sv
// rtl/fp_minmax_reduce.sv - streaming IEEE-754 FMIN/FMAX packet reduction with sticky NV flag
// Optional FP_MINMAX_INDEX_EN adds out_idx (arg-min/arg-max position, wraps modulo 2^CNT_W).
module fp_minmax_reduce #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  input  logic                   in_last,
  input  logic                   in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_nv
`ifdef FP_MINMAX_INDEX_EN
  ,
  output logic [CNT_W-1:0]       out_idx
`endif
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] CANON = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t         state, state_next;
  logic [W-1:0]   acc;
  logic           op;
  logic           nv;
  logic [W-1:0]   sel_data;
  logic           take_new;
  logic           accept;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
  endfunction

  function automatic logic is_snan(input logic [W-1:0] x);
    return is_nan(x) && !x[MAN_W-1];
  endfunction

  // Sign-magnitude total order; a sign mismatch alone decides, which puts -0 below +0.
  function automatic logic lt(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a[W-1] != b[W-1])
      return a[W-1];
    else if (a[W-1])
      return a[W-2:0] > b[W-2:0];
    else
      return a[W-2:0] < b[W-2:0];
  endfunction

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b1;
    out_valid  = 1'b0;
    case (state)
      IDLE:  if (accept) state_next = in_last ? DONE : ACCUM;
      ACCUM: if (accept && in_last) state_next = DONE;
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ties leave take_new low so the accumulator (and its index) survives.
  always_comb begin
    sel_data = acc;
    take_new = 1'b0;
    if (is_nan(acc) && is_nan(in_data)) begin
      sel_data = CANON;
    end else if (is_nan(acc)) begin
      sel_data = in_data;
      take_new = 1'b1;
    end else if (!is_nan(in_data) && (op ? lt(acc, in_data) : lt(in_data, acc))) begin
      sel_data = in_data;
      take_new = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      op  <= 1'b0;
      nv  <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc <= in_data;
        op  <= in_op;
        nv  <= is_snan(in_data);
      end else begin
        acc <= sel_data;
        nv  <= nv | is_snan(in_data);
      end
    end
  end

  assign out_data = out_valid ? (is_nan(acc) ? CANON : acc) : '0;
  assign out_nv   = out_valid && nv;

`ifdef FP_MINMAX_INDEX_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        cnt <= CNT_W'(1);
        idx <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (take_new) idx <= cnt;
      end
    end
  end

  assign out_idx = out_valid ? idx : '0;
`else
  logic unused_index_cfg;
  assign unused_index_cfg = take_new ^ (CNT_W[0]);
`endif

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// tb/tb_fp_minmax_reduce.sv - randomized self-checking bench for fp_minmax_reduce
// Reference: order-key reduction over the non-NaN elements of each packet.
module tb_fp_minmax_reduce;

  localparam int TB_CNT_W = 2;
  localparam logic [31:0] CANON = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, in_op;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_nv;
  logic [31:0] out_data;
  logic [TB_CNT_W-1:0] out_idx_obs;
`ifdef FP_MINMAX_INDEX_EN
  logic [TB_CNT_W-1:0] out_idx;
  assign out_idx_obs = out_idx;
`else
  assign out_idx_obs = '0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] pkt[$];
  logic [31:0] obs_data;
  logic        obs_nv;
  logic [TB_CNT_W-1:0] obs_idx;

  fp_minmax_reduce #(.EXP_W(8), .MAN_W(23), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_nv(out_nv)
`ifdef FP_MINMAX_INDEX_EN
    , .out_idx(out_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit f_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  // Monotone unsigned key for the IEEE total order (negatives inverted, positives offset).
  function automatic logic [31:0] order_key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  task automatic model(input bit op, output logic [31:0] d, output bit nv, output int idx);
    bit found = 0;
    logic [31:0] best = 0;
    nv = 0; idx = 0;
    for (int i = 0; i < pkt.size(); i++) begin
      if (f_is_nan(pkt[i])) begin
        if (!pkt[i][22]) nv = 1;
      end else if (!found || (op ? order_key(pkt[i]) > order_key(best)
                                 : order_key(pkt[i]) < order_key(best))) begin
        best = pkt[i]; idx = i; found = 1;
      end
    end
    d = found ? best : CANON;
  endtask

  function automatic logic [31:0] rand_elem();
    logic [31:0] r = $urandom;
    logic [21:0] p;
    case ($urandom_range(0, 9))
      0: return {r[31], 31'h0};
      1: return {r[31], 8'hFF, 23'h0};
      2: return {r[31], 8'hFF, 1'b1, r[21:0]};
      3: begin p = r[21:0]; if (p == 0) p = 1; return {r[31], 8'hFF, 1'b0, p}; end
      4: return {r[31], 8'h00, r[22:0]};
      5: return r[0] ? 32'h3F80_0000 : 32'hBF80_0000;
      default: return r;
    endcase
  endfunction

  task automatic run_pkt(input bit op, input int hold, input bit gaps);
    logic [31:0] exp_d;
    bit exp_nv;
    int exp_i;
    int n = pkt.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 0; in_last = 1; in_data = $urandom; in_op = ~op;
        @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1; in_data = pkt[i]; in_last = (i == n - 1);
      in_op = (i == 0) ? op : ~op;
      check("in_ready_beat", in_ready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 0; in_last = 0;
    check("out_valid_latency", out_valid, 1);
    obs_data = out_data; obs_nv = out_nv; obs_idx = out_idx_obs;
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, obs_data);
      check("hold_nv", out_nv, obs_nv);
      check("hold_in_ready", in_ready, 0);
    end
    model(op, exp_d, exp_nv, exp_i);
    check("data", out_data, exp_d);
    check("nv", out_nv, exp_nv);
`ifdef FP_MINMAX_INDEX_EN
    check("idx", out_idx, exp_i % (1 << TB_CNT_W));
    check("hold_idx", out_idx, obs_idx);
`endif
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_last = 0; in_op = 0; in_data = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_nv", out_nv, 0);

    pkt = '{32'h3F80_0000, 32'hC000_0000, 32'h4040_0000};
    run_pkt(1, 0, 0);
    check("max3", obs_data, 32'h4040_0000);
    check("max3_nv", obs_nv, 0);
`ifdef FP_MINMAX_INDEX_EN
    check("max3_idx", obs_idx, 2);
`endif

    pkt = '{32'h0000_0000, 32'h8000_0000};
    run_pkt(0, 0, 0);
    check("min_zero", obs_data, 32'h8000_0000);
    run_pkt(1, 0, 0);
    check("max_zero", obs_data, 32'h0000_0000);
    pkt = '{32'h8000_0000, 32'h8000_0000};
    run_pkt(0, 0, 0);
    check("tie_data", obs_data, 32'h8000_0000);
`ifdef FP_MINMAX_INDEX_EN
    check("tie_idx", obs_idx, 0);
`endif

    pkt = '{32'h7FC0_0000, 32'hBF80_0000};
    run_pkt(0, 0, 0);
    check("qnan_min", obs_data, 32'hBF80_0000);
    check("qnan_min_nv", obs_nv, 0);
`ifdef FP_MINMAX_INDEX_EN
    check("qnan_min_idx", obs_idx, 1);
`endif
    pkt = '{32'h7F80_0001, 32'h7FC0_0001};
    run_pkt(1, 0, 0);
    check("both_nan", obs_data, CANON);
    check("both_nan_nv", obs_nv, 1);
    pkt = '{32'hFF80_0001};
    run_pkt(0, 0, 0);
    check("single_snan", obs_data, CANON);
    check("single_snan_nv", obs_nv, 1);

    pkt = '{32'hFF80_0000, 32'h0000_0001};
    run_pkt(0, 3, 0);
    check("bp_min", obs_data, 32'hFF80_0000);
    run_pkt(1, 0, 0);
    check("bp_next_max", obs_data, 32'h0000_0001);

    // Abort mid-packet; the polluting beats must not leak into the next packet.
    @(negedge clk);
    in_valid = 1; in_data = 32'h7F80_0001; in_last = 0; in_op = 1;
    @(posedge clk);
    @(negedge clk);
    in_data = 32'h7F7F_FFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_nv", out_nv, 0);
    check("abort_out_data", out_data, 0);
    check("abort_in_ready", in_ready, 1);
    pkt = '{32'h4000_0000};
    run_pkt(1, 0, 0);
    check("after_abort", obs_data, 32'h4000_0000);
    check("after_abort_nv", obs_nv, 0);

`ifdef FP_MINMAX_INDEX_EN
    pkt = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
            32'h3F00_0000, 32'h4080_0000, 32'h7F80_0000};
    run_pkt(1, 0, 0);
    check("wrap_idx", obs_idx, 1);
`endif

    for (int t = 0; t < 200; t++) begin
      int len = $urandom_range(1, 8);
      pkt.delete();
      for (int k = 0; k < len; k++) pkt.push_back(rand_elem());
      run_pkt($urandom_range(0, 1), $urandom_range(0, 3), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_minmax_reduce.md
Name: fp_minmax_reduce

Overview:
Streaming IEEE-754 min/max reduction unit with RISC-V FMIN/FMAX semantics. Accepts a packet of floating-point elements over a valid/ready stream and returns one min or max result per packet, with an invalid-operation (NV) flag. Supports -0 < +0 ordering, NaN propagation rules and canonical-NaN output. Sits beside the FPU datapath and serves vector/reduction sequences.

Parameters:
EXP_W, 8, exponent width in bits
MAN_W, 23, mantissa (fraction) width in bits
CNT_W, 8, element-index counter width; used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input element valid
in_ready  out  1  unit can accept an element
in_data  in  1+EXP_W+MAN_W  element: sign, exponent, mantissa
in_last  in  1  marks the final element of the packet
in_op  in  1  0 = min, 1 = max; sampled on the first beat only
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_data  out  1+EXP_W+MAN_W  reduction result
out_nv  out  1  sticky invalid flag: an sNaN was seen in the packet

Behaviour:
- Single clock domain. rst is synchronous and active-high.
- Reset state: IDLE. in_ready=1, out_valid=0, out_data=0, out_nv=0, accumulator=0.
- A transfer occurs on any edge where valid and ready are both high.
- States:
  - IDLE: in_ready=1. First beat loads the accumulator with in_data, latches op from in_op and sets NV to (in_data is sNaN). With in_last=1 go to DONE, otherwise go to ACCUM.
  - ACCUM: in_ready=1. Each beat updates acc = select(acc, in_data, op) and NV |= (in_data is sNaN). in_op is ignored. With in_last=1 go to DONE.
  - DONE: in_ready=0, out_valid=1. out_data and out_nv are held stable until out_ready=1, then go to IDLE.
- Latency and throughput:
  - out_valid rises the cycle after the last beat is accepted.
  - One element per cycle within a packet.
  - One cycle minimum between packets. A new first beat is never accepted in the cycle of the output handshake.
- Classification:
  - NaN: exponent all ones and mantissa nonzero.
  - sNaN: a NaN with mantissa MSB = 0.
  - Canonical NaN: sign 0, exponent all ones, mantissa MSB 1, rest 0 (0x7FC00000 at defaults).
- select(a, b):
  - Both operands NaN: canonical NaN.
  - Exactly one operand NaN: the other operand.
  - Otherwise: total numeric order, with -0 < +0. Sign-magnitude compare: a negative operand with larger magnitude is smaller.
  - Ties (bit-identical values): keep the accumulator.
- Output: if the final acc is a NaN (including a single-element NaN packet), out_data is the canonical NaN; otherwise out_data = acc bits unchanged.
- Infinities and subnormals are ordinary ordered values. No flushing.
- in_last asserted on a cycle with in_valid=0 has no effect.
- rst asserted mid-packet or in DONE aborts the packet: state returns to IDLE, all outputs take their reset values, no partial result is emitted.

Optional Feature:
Macro FP_MINMAX_INDEX_EN.
- Defined:
  - Adds output port out_idx [CNT_W-1:0], the 0-based position in the packet of the element that produced out_data (arg-min/arg-max).
  - Ties keep the earlier index.
  - A replacement by the other operand in the one-NaN case takes the new element's index.
  - Both-NaN keeps the accumulator index.
  - The counter wraps modulo 2^CNT_W.
  - out_idx resets to 0 and is held stable in DONE.
- Not defined: the port, counter and index register are absent. Behaviour is otherwise identical.

Test Plan:
- Max over {0x3F800000, 0xC0000000, 0x40400000}, last on beat 3 -> out_data=0x40400000, out_nv=0, out_valid on the cycle after beat 3, out_idx=2.
- Signed zeros:
  - min {0x00000000, 0x80000000} -> 0x80000000.
  - max of the same pair -> 0x00000000.
  - min {0x80000000, 0x80000000} -> out_idx=0.
- NaN handling:
  - min {0x7FC00000, 0xBF800000} -> 0xBF800000, nv=0, idx=1.
  - max {0x7F800001, 0x7FC00001} -> 0x7FC00000, nv=1.
  - min {0xFF800001} single beat -> 0x7FC00000, nv=1.
- Backpressure: hold out_ready=0 for 3 cycles after a min packet {0xFF800000, 0x00000001} -> out_data=0xFF800000 stable, in_ready=0 throughout. After the handshake, in_ready=1 next cycle. A new packet with in_op=1 uses max.
- Reset: assert rst after beat 2 of a 4-beat packet -> next cycle IDLE, out_valid=0, out_nv=0. A following packet {0x40000000} (max) -> 0x40000000, unaffected by the aborted data.
- Wrap with CNT_W=2: max over 6 beats with the largest value 0x7F800000 at position 5 -> out_idx=1.
